// File: rtl/interrupts.sv
// Interrupt controller: IF/IE registers on the memory bus, with edge-detected request inputs and a fixed-priority request/ack handshake to the CPU.
// Latency: a request input rising with IF clear, its IE bit set, ime=1 and the FSM idle raises int_req two clock edges later.
// Backpressure: a raised request holds its vector stable until int_ack, or drops when ime or the pending bit goes away.
module interrupts #(
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0008
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [15:0] addr_ext,
  inout  wire  [7:0]  data_ext,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic        vblank_interrupt,
  input  logic        lcdc_interrupt,
  input  logic        timer_interrupt,
  input  logic        serial_interrupt,
  input  logic        joypad_interrupt,
  input  logic        ime,
  input  logic        int_ack,
  output logic        int_req,
  output logic [15:0] int_vector
);

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [4:0]  req_in;
  logic [4:0]  req_prev;
  logic [4:0]  rise;

  logic [4:0]  if_q;
  logic [4:0]  if_base;
  logic [4:0]  if_keep;
  logic [4:0]  if_next;
  logic [4:0]  ack_mask;
  logic [7:0]  ie_q;
  logic [7:0]  ie_next;

  logic [4:0]  pending;
  logic [2:0]  prio_idx;
  logic [2:0]  idx_q;
  logic [2:0]  idx_next;
  logic        ack_clear;

  logic        sel_if;
  logic        sel_ie;
  logic        wr_if;
  logic        wr_ie;
  logic        rd_en;
  logic [7:0]  rd_data;

  // Request inputs in IF/IE bit order; a rising edge is "high now, low at the last edge".
  assign req_in = {joypad_interrupt, serial_interrupt, timer_interrupt,
                   lcdc_interrupt, vblank_interrupt};
  assign rise   = req_in & ~req_prev;

  // Bus decode. The address bus is only ever sampled here.
  assign sel_if = (addr_ext == ADDR_IF);
  assign sel_ie = (addr_ext == ADDR_IE);
  assign wr_if  = mem_we && sel_if;
  assign wr_ie  = mem_we && sel_ie;

  // Reads are combinational in the strobe cycle; the bus is released during reset.
  assign rd_en   = mem_re && !reset && (sel_if || sel_ie);
  assign rd_data = sel_if ? {3'b111, if_q} : ie_q;
  assign data_ext = rd_en ? rd_data : 8'hzz;

  assign pending = if_q & ie_q[4:0];

  // Lowest set pending index wins.
  always_comb begin
    prio_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) prio_idx = 3'(i);
    end
  end

  // Next register values: bus write first, then the ack clear, then new edges on top
  // so an event arriving in the ack cycle is never lost. if_keep omits the ack clear
  // and is what the FSM uses to decide whether the current request is still wanted.
  always_comb begin
    ie_next  = wr_ie ? data_ext : ie_q;
    if_base  = wr_if ? data_ext[4:0] : if_q;
    ack_mask = ack_clear ? (5'b00001 << idx_q) : 5'b00000;
    if_keep  = if_base | rise;
    if_next  = (if_base & ~ack_mask) | rise;
  end

  // Request handshake FSM: latch the winner in IDLE, hold it in REQ, one idle cycle after ack.
  always_comb begin
    state_next = state;
    idx_next   = idx_q;
    ack_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (ime && (pending != 5'd0)) begin
          state_next = REQ;
          idx_next   = prio_idx;
        end
      end
      REQ: begin
        if (int_ack) begin
          ack_clear  = 1'b1;
          state_next = ACKED;
        end else if (!ime || !(if_keep[idx_q] && ie_next[idx_q])) begin
          // Withdrawn request: IF is left as the bus/edges make it.
          state_next = IDLE;
        end
      end
      ACKED: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, registers and edge-detect samples; reset overrides every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      idx_q    <= 3'd0;
      if_q     <= 5'd0;
      ie_q     <= 8'd0;
      req_prev <= 5'd0;
    end else begin
      state    <= state_next;
      idx_q    <= idx_next;
      if_q     <= if_next;
      ie_q     <= ie_next;
      req_prev <= req_in;
    end
  end

  // CPU-facing outputs are only live in REQ and are forced quiet during reset.
  always_comb begin
    int_req    = (state == REQ) && !reset;
    int_vector = 16'h0000;
    if (int_req) begin
      int_vector = VECTOR_BASE + 16'(idx_q) * VECTOR_STRIDE;
    end
  end

endmodule

// File: tb/tb_interrupts.sv
// Directed bench for the interrupt controller with a scoreboard queue of expected values.
// Expectations are pushed as stimulus is driven and popped when the DUT output is sampled.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_interrupts;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] addr_drv;
  logic [7:0]  data_drv;
  logic        data_oe;
  logic        mem_re, mem_we;
  logic        vblank_interrupt, lcdc_interrupt, timer_interrupt;
  logic        serial_interrupt, joypad_interrupt;
  logic        ime, int_ack;
  logic        int_req;
  logic [15:0] int_vector;

  wire  [15:0] addr_bus;
  wire  [7:0]  data_bus;

  assign addr_bus = addr_drv;
  assign data_bus = data_oe ? data_drv : 8'hzz;

  always #5 clock = ~clock;

  interrupts dut (
    .clock            (clock),
    .reset            (reset),
    .addr_ext         (addr_bus),
    .data_ext         (data_bus),
    .mem_re           (mem_re),
    .mem_we           (mem_we),
    .vblank_interrupt (vblank_interrupt),
    .lcdc_interrupt   (lcdc_interrupt),
    .timer_interrupt  (timer_interrupt),
    .serial_interrupt (serial_interrupt),
    .joypad_interrupt (joypad_interrupt),
    .ime              (ime),
    .int_ack          (int_ack),
    .int_req          (int_req),
    .int_vector       (int_vector)
  );

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Combinational bus read within the current cycle; consumes no clock edge.
  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    addr_drv = a;
    mem_re   = 1'b1;
    #1;
    d        = data_bus;
    mem_re   = 1'b0;
    addr_drv = 16'h0000;
  endtask

  // Bus write; takes effect at the next edge.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr_drv = a;
    data_drv = d;
    data_oe  = 1'b1;
    mem_we   = 1'b1;
    step();
    mem_we   = 1'b0;
    data_oe  = 1'b0;
    addr_drv = 16'h0000;
  endtask

  task automatic expect_rd(input string tag, input logic [15:0] a, input logic [7:0] v);
    logic [7:0] d;
    push(tag, {8'h00, v});
    rd(a, d);
    chk({8'h00, d});
  endtask

  task automatic exp_out(input string tag, input logic r, input logic [15:0] v);
    push({tag, "_req"}, {15'd0, r});
    push({tag, "_vec"}, v);
  endtask

  task automatic check_out();
    chk({15'd0, int_req});
    chk(int_vector);
  endtask

  // Read during reset must not return register contents (0xE0 if driven).
  task automatic check_undriven(input string tag);
    logic [7:0] d;
    push(tag, 16'd1);
    rd(ADDR_IF, d);
    chk({15'd0, ((d === 8'hzz) || (d === 8'h00))});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr_drv = 16'h0000; data_drv = 8'h00; data_oe = 1'b0;
    mem_re = 1'b0; mem_we = 1'b0; ime = 1'b0; int_ack = 1'b0;
    vblank_interrupt = 1'b0; lcdc_interrupt = 1'b0; timer_interrupt = 1'b0;
    serial_interrupt = 1'b0; joypad_interrupt = 1'b0;

    // Reset state
    exp_out("rst", 1'b0, 16'h0000);
    step(); step();
    check_out();
    check_undriven("rst_bus_released");
    reset = 1'b0;
    step();
    expect_rd("rst_if", ADDR_IF, 8'hE0);
    expect_rd("rst_ie", ADDR_IE, 8'h00);

    // Single timer pulse, two-edge latency, ack
    wr(ADDR_IE, 8'h04);
    ime = 1'b1;
    exp_out("t1_wait", 1'b0, 16'h0000);
    timer_interrupt = 1'b1; step(); timer_interrupt = 1'b0;
    check_out();
    expect_rd("t1_if_set", ADDR_IF, 8'hE4);
    exp_out("t1_req", 1'b1, 16'h0050);
    step();
    check_out();
    exp_out("t1_acked", 1'b0, 16'h0000);
    int_ack = 1'b1; step(); int_ack = 0;
    check_out();
    expect_rd("t1_if_clr", ADDR_IF, 8'hE0);
    step();

    // Simultaneous vblank and joypad: priority order
    wr(ADDR_IE, 8'h1F);
    vblank_interrupt = 1'b1; joypad_interrupt = 1'b1; step();
    vblank_interrupt = 1'b0; joypad_interrupt = 1'b0;
    expect_rd("t2_if_both", ADDR_IF, 8'hF1);
    exp_out("t2_vblank", 1'b1, 16'h0040);
    step();
    check_out();
    exp_out("t2_acked", 1'b0, 16'h0000);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    check_out();
    expect_rd("t2_if_after_ack", ADDR_IF, 8'hF0);
    exp_out("t2_idle", 1'b0, 16'h0000);
    step();
    check_out();
    exp_out("t2_joypad", 1'b1, 16'h0060);
    step();
    check_out();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    step();

    // ime gating
    ime = 1'b0;
    timer_interrupt = 1'b1; step(); timer_interrupt = 1'b0;
    step(); step();
    exp_out("t3_masked", 1'b0, 16'h0000);
    check_out();
    expect_rd("t3_if", ADDR_IF, 8'hE4);
    ime = 1'b1;
    exp_out("t3_ime_req", 1'b1, 16'h0050);
    step();
    check_out();

    // Bus write clears the pending bit while in REQ
    exp_out("t4_withdraw", 1'b0, 16'h0000);
    wr(ADDR_IF, 8'h00);
    check_out();
    exp_out("t4_stay_idle", 1'b0, 16'h0000);
    step();
    check_out();
    expect_rd("t4_if", ADDR_IF, 8'hE0);

    // Ack coincident with a new timer edge
    timer_interrupt = 1'b1; step(); timer_interrupt = 1'b0;
    exp_out("t5_req", 1'b1, 16'h0050);
    step();
    check_out();
    int_ack = 1'b1; timer_interrupt = 1'b1;
    exp_out("t5_acked", 1'b0, 16'h0000);
    step();
    int_ack = 1'b0; timer_interrupt = 1'b0;
    check_out();
    expect_rd("t5_if_kept", ADDR_IF, 8'hE4);
    exp_out("t5_idle", 1'b0, 16'h0000);
    step();
    check_out();
    exp_out("t5_again", 1'b1, 16'h0050);
    step();
    check_out();

    // Reset in the middle of REQ
    reset = 1'b1;
    exp_out("t6_rst", 1'b0, 16'h0000);
    step();
    check_out();
    check_undriven("t6_bus_released");
    reset = 1'b0;
    expect_rd("t6_if", ADDR_IF, 8'hE0);
    expect_rd("t6_ie", ADDR_IE, 8'h00);
    exp_out("t6_quiet", 1'b0, 16'h0000);
    step();
    check_out();

    // Latched index holds while a higher-priority bit arrives
    wr(ADDR_IE, 8'h1F);
    timer_interrupt = 1'b1; step(); timer_interrupt = 1'b0;
    exp_out("t7_timer", 1'b1, 16'h0050);
    step();
    check_out();
    exp_out("t7_hold", 1'b1, 16'h0050);
    vblank_interrupt = 1'b1; step(); vblank_interrupt = 1'b0;
    check_out();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    expect_rd("t7_if", ADDR_IF, 8'hE1);
    step();
    exp_out("t7_vblank_next", 1'b1, 16'h0040);
    step();
    check_out();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    step();

    // int_ack outside REQ has no effect
    ime = 1'b0;
    int_ack = 1'b1;
    timer_interrupt = 1'b1; step(); timer_interrupt = 1'b0;
    step();
    int_ack = 1'b0;
    expect_rd("t8_if_not_cleared", ADDR_IF, 8'hE4);
    exp_out("t8_idle", 1'b0, 16'h0000);
    check_out();
    wr(ADDR_IF, 8'h00);
    expect_rd("t8_if_written", ADDR_IF, 8'hE0);

    // Input already high at reset release is captured on the first edge
    reset = 1'b1;
    joypad_interrupt = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    joypad_interrupt = 1'b0;
    expect_rd("t9_if_after_release", ADDR_IF, 8'hF0);
    exp_out("t9_ie_zero", 1'b0, 16'h0000);
    check_out();

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interrupts.md
INTERRUPTS -- requirements
Module: interrupts

Interface
REQ-001 SHALL have parameter VECTOR_BASE, default 16'h0040, giving the vector of request bit 0.
REQ-002 SHALL have parameter VECTOR_STRIDE, default 16'h0008, giving the vector spacing per bit index.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port addr_ext, inout, 16, the memory bus address; this block only samples it.
REQ-006 SHALL have port data_ext, inout, 8, the memory bus data; driven only during a register read.
REQ-007 SHALL have ports mem_re and mem_we, input, 1 each, bus read and write strobes.
REQ-008 SHALL have request inputs vblank_interrupt, lcdc_interrupt, timer_interrupt, serial_interrupt and joypad_interrupt, input, 1 each, mapped to IF/IE bits 0 to 4 in that order.
REQ-009 SHALL have port ime, input, 1, the CPU master interrupt enable.
REQ-010 SHALL have port int_ack, input, 1, the CPU acknowledge of the current request.
REQ-011 SHALL have port int_req, output, 1, interrupt request to the CPU.
REQ-012 SHALL have port int_vector, output, 16, the service address for the current request.

Function
REQ-013 SHALL keep 5-bit IF (MMIO 0xFF0F) and 8-bit IE (MMIO 0xFFFF) registers.
REQ-014 SHALL, when mem_re is high and addr_ext matches, drive data_ext with {3'b111, IF} for 0xFF0F or IE for 0xFFFF in the same cycle, and tri-state data_ext otherwise.
REQ-015 SHALL, when mem_we is high and addr_ext matches, load IF from data_ext[4:0] or IE from data_ext[7:0] at the next edge.
REQ-016 SHALL register each request input once per cycle and detect a rising edge as input=1 with previous sample=0.
REQ-017 SHALL set IF[i] at the edge on which rising edge i is detected.
REQ-018 SHALL, on a same-cycle IF write and rising edge, load IF from (write data OR edge bits).
REQ-019 SHALL define pending as IF[4:0] & IE[4:0], with the lowest set index having the highest priority.
REQ-020 SHALL implement a three-state FSM with states IDLE, REQ and ACKED.
REQ-021 SHALL, in IDLE, go to REQ when ime=1 and pending!=0, latching idx as the highest-priority pending bit.
REQ-022 SHALL, in REQ, hold int_req=1 and int_vector=VECTOR_BASE+idx*VECTOR_STRIDE stable (0x0040/48/50/58/60).
REQ-023 SHALL, in REQ with int_ack=1, clear IF[idx] at that edge and go to ACKED.
REQ-024 SHALL, in REQ with int_ack=0, go to IDLE without clearing IF when ime=0 or IF[idx]&IE[idx]=0 (including via a same-cycle bus write).
REQ-025 SHALL keep idx fixed in REQ even if a higher-priority bit becomes pending; it is serviced in the next round.
REQ-026 SHALL spend exactly one cycle in ACKED with int_req=0, then go to IDLE.
REQ-027 SHALL drive int_req=0 and int_vector=16'h0000 in IDLE and ACKED.
REQ-028 SHALL ignore int_ack outside REQ.
REQ-029 SHALL, on a same-cycle ack clear and rising edge of bit idx, leave IF[idx]=1 (new event not lost).
REQ-030 SHALL, on a same-cycle ack and IF write, apply the write and then clear IF[idx] unless the same-cycle edge sets it.
REQ-031 SHALL give a latency of int_req rising 2 edges after a request input first seen high with IF=0, IE bit set, ime=1 and FSM in IDLE.

Reset
REQ-032 SHALL, with reset=1 at an edge, clear IF, IE, idx and all edge-detect samples to 0 and enter IDLE, overriding all other inputs.
REQ-033 SHALL hold int_req=0 and int_vector=16'h0000 and leave data_ext undriven while in reset.
REQ-034 SHALL abandon a request in progress on reset mid-REQ, with no IF clear beyond the reset itself.
REQ-035 SHALL set IF[i] on the first edge after reset release if input i is high then.

Verification
REQ-036 SHALL cover: IE=0x04, ime=1, one-cycle timer_interrupt pulse -> IF=0x04, int_req high with int_vector=0x0050 two edges later; int_ack -> IF=0x00, int_req low.
REQ-037 SHALL cover: IE=0x1F, vblank and joypad pulse together -> vector 0x0040 first; after ack and ACKED, vector 0x0060.
REQ-038 SHALL cover: ime=0 with timer pending -> int_req stays 0 and IF reads 0xE4; ime raised -> int_req after 1 edge.
REQ-039 SHALL cover: in REQ for bit 2, CPU writes 0x00 to 0xFF0F -> int_req drops next cycle and no ack is needed.
REQ-040 SHALL cover: ack of bit 2 in the same cycle as a new timer_interrupt edge -> IF[2] stays 1 and a second request follows after ACKED.
REQ-041 SHALL cover: reset asserted during REQ -> next cycle int_req=0, IF=0x00, IE=0x00, reads 0xE0 and 0x00.
